ud_count_display: RTL and testbench
===================================

Name: ud_count_display

Overview:
- Downstream consumer of the 4-bit JK up/down counter.
- Resynchronises the counter's ripple-clocked q[3:0] and direction control into the system clock domain.
- Filters glitches seen while the ripple outputs settle, and accepts a value only after it has held steady.
- Drives a registered hex 7-segment display, flags wrap-around (15->0 counting up, 0->15 counting down), and keeps a signed-style saturating wrap tally for the front panel.

Parameters:
- STABLE_CYCLES, 4, consecutive system clocks a synchronised value must hold before acceptance; legal range 1..15.
- WRAP_W, 8, width of the wrap_cnt tally.

Ports:
- clk  input  1  system clock; all state on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- count_in  input  4  counter q[3:0]; asynchronous to clk.
- dir_up  input  1  counter direction control; 1 = counting up, 0 = counting down; asynchronous.
- clr  input  1  synchronous clear of wrap_cnt and pulses; does not affect the display.
- digit_val  output  4  last accepted count value.
- valid  output  1  high once the first value has been accepted.
- seg  output  7  {g,f,e,d,c,b,a}, active-high, registered.
- ovf_pulse  output  1  one-clock pulse on an up wrap (15->0).
- unf_pulse  output  1  one-clock pulse on a down wrap (0->15).
- wrap_cnt  output  WRAP_W  saturating tally; +1 per overflow, -1 per underflow.

Behaviour:
- Reset (rst_n low, immediate):
  - sync stages, cand, stab_cnt, digit_val, valid, ovf_pulse, unf_pulse and wrap_cnt all go to 0.
  - seg goes to 7'h40 (dash).
  - Reset mid-filter discards any partial candidate.
- Synchroniser: count_in and dir_up each pass through two flops, giving s_cnt and s_dir.
- Stability filter, evaluated each clock:
  - If s_cnt != cand: cand <= s_cnt and stab_cnt <= 0.
  - Else, if stab_cnt < STABLE_CYCLES: stab_cnt increments.
- Accept condition: s_cnt == cand AND stab_cnt == STABLE_CYCLES-1 AND (cand != digit_val OR valid == 0).
- On accept:
  - digit_val <= cand and valid <= 1.
  - Re-acceptance of an unchanged value never occurs; stab_cnt saturates.
- Latency:
  - digit_val updates on rising edge STABLE_CYCLES+3 after count_in changes, counting the first edge after the change as edge 1.
  - seg follows one edge later.
  - ovf_pulse and unf_pulse assert on the same edge as digit_val.
- Wrap detection, on accept with valid == 1 only (the first acceptance after reset never pulses):
  - Previous digit_val 15, new 0, and s_dir 1: ovf_pulse high for one clock; wrap_cnt +1, saturating at all-ones.
  - Previous 0, new 15, and s_dir 0: unf_pulse high for one clock; wrap_cnt -1, saturating at 0.
  - Any other transition, including a 15->0 jump with s_dir 0 or a skipped value: no pulse, tally unchanged.
- Pulses are low on every cycle without a qualifying accept.
- clr:
  - Forces wrap_cnt <= 0 and both pulses to 0 that cycle.
  - clr wins over a coincident wrap event.
  - digit_val, valid and seg are unaffected.
- seg encoding, applied when valid == 1; seg = 7'h40 while valid == 0:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- Glitch rejection: a value held fewer than STABLE_CYCLES+1 consecutive synchronised clocks is never accepted.

Test Plan:
- Reset, then hold count_in=5, dir_up=1, STABLE_CYCLES=4 -> first 6 edges: valid=0, seg=40. Edge 7: digit_val=5, valid=1. Edge 8: seg=6D. No pulses.
- Count up 13,14,15,0, each held 10 clocks, dir_up=1 -> on acceptance of 0: ovf_pulse high exactly one clock, wrap_cnt 0->1, seg=3F.
- dir_up=0, count 1,0,15, each held 10 clocks, starting wrap_cnt=1 -> one unf_pulse, wrap_cnt=0. Repeat the underflow -> pulse asserts, wrap_cnt stays 0 (saturated).
- From accepted 7, drive count_in 7->3 for 2 clocks, then back to 7 -> digit_val stays 7, no pulse, seg unchanged at 07.
- Force wrap_cnt to 255 (WRAP_W=8) and trigger an overflow -> wrap_cnt stays 255, pulse still asserts. Assert clr on the same cycle as a qualifying accept -> wrap_cnt=0, no pulse, digit_val still updates.
- Assert rst_n low mid-filter (stab_cnt=2) -> all outputs zero, seg=40 immediately. Release -> the value requires the full STABLE_CYCLES+3 latency again.

Source files
------------

// File: rtl/ud_count_display.sv
// Front-panel consumer of the ripple JK up/down counter: resynchronises q[3:0] and direction,
// debounces ripple glitches, drives a registered hex 7-segment digit and tracks wrap events.

module ud_count_display #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned WRAP_W        = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        count_in,
    input  logic              dir_up,
    input  logic              clr,
    output logic [3:0]        digit_val,
    output logic              valid,
    output logic [6:0]        seg,
    output logic              ovf_pulse,
    output logic              unf_pulse,
    output logic [WRAP_W-1:0] wrap_cnt
);

    localparam logic [3:0] StableMax  = 4'(STABLE_CYCLES);
    localparam logic [3:0] StableLast = 4'(STABLE_CYCLES - 1);
    localparam logic [6:0] SegDash    = 7'h40;

    logic [3:0]        cnt_meta_q, cnt_sync_q;
    logic              dir_meta_q, dir_sync_q;
    logic [3:0]        cand_q, cand_d;
    logic [3:0]        stab_q, stab_d;
    logic [3:0]        digit_q, digit_d;
    logic              valid_q, valid_d;
    logic [6:0]        seg_q, seg_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic [WRAP_W-1:0] wrap_q, wrap_d;

    logic same, accept, ovf_evt, unf_evt;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        unique case (v)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            4'hF: s = 7'h71;
        endcase
        return s;
    endfunction

    // Two-flop synchronisers; both inputs come from the ripple-clocked counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_meta_q <= 4'd0;
            cnt_sync_q <= 4'd0;
            dir_meta_q <= 1'b0;
            dir_sync_q <= 1'b0;
        end else begin
            cnt_meta_q <= count_in;
            cnt_sync_q <= cnt_meta_q;
            dir_meta_q <= dir_up;
            dir_sync_q <= dir_meta_q;
        end
    end

    always_comb begin
        cand_d = cand_q;
        stab_d = stab_q;
        same   = (cnt_sync_q == cand_q);
        if (!same) begin
            cand_d = cnt_sync_q;
            stab_d = 4'd0;
        end else if (stab_q < StableMax) begin
            stab_d = stab_q + 4'd1;
        end
    end

    // stab_q saturates above StableLast, so a held value is accepted at most once.
    assign accept  = same && (stab_q == StableLast) && ((cand_q != digit_q) || !valid_q);
    assign ovf_evt = accept && valid_q && (digit_q == 4'hF) && (cand_q == 4'h0) && dir_sync_q;
    assign unf_evt = accept && valid_q && (digit_q == 4'h0) && (cand_q == 4'hF) && !dir_sync_q;

    always_comb begin
        digit_d = digit_q;
        valid_d = valid_q;
        if (accept) begin
            digit_d = cand_q;
            valid_d = 1'b1;
        end
    end

    always_comb begin
        wrap_d = wrap_q;
        ovf_d  = 1'b0;
        unf_d  = 1'b0;
        if (clr) begin
            wrap_d = '0;
        end else if (ovf_evt) begin
            ovf_d = 1'b1;
            if (wrap_q != '1) begin
                wrap_d = wrap_q + WRAP_W'(1);
            end
        end else if (unf_evt) begin
            unf_d = 1'b1;
            if (wrap_q != '0) begin
                wrap_d = wrap_q - WRAP_W'(1);
            end
        end
    end

    // Decoded from the registered digit, hence one clock behind digit_val.
    always_comb begin
        seg_d = SegDash;
        if (valid_q) begin
            seg_d = hex_to_seg(digit_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_q  <= 4'd0;
            stab_q  <= 4'd0;
            digit_q <= 4'd0;
            valid_q <= 1'b0;
            seg_q   <= SegDash;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            wrap_q  <= '0;
        end else begin
            cand_q  <= cand_d;
            stab_q  <= stab_d;
            digit_q <= digit_d;
            valid_q <= valid_d;
            seg_q   <= seg_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            wrap_q  <= wrap_d;
        end
    end

    assign digit_val = digit_q;
    assign valid     = valid_q;
    assign seg       = seg_q;
    assign ovf_pulse = ovf_q;
    assign unf_pulse = unf_q;
    assign wrap_cnt  = wrap_q;

endmodule

// File: tb/tb_ud_count_display.sv
// Scoreboard bench for ud_count_display: stimulus queues expected accept events, a monitor
// matches every observed output change against them and tracks the expected seg value.

module tb_ud_count_display;

    localparam int STABLE = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] count_in = 4'd0;
    logic       dir_up = 1'b1;
    logic       clr = 1'b0;
    logic [3:0] digit_val;
    logic       valid;
    logic [6:0] seg;
    logic       ovf_pulse;
    logic       unf_pulse;
    logic [7:0] wrap_cnt;

    ud_count_display #(
        .STABLE_CYCLES(STABLE),
        .WRAP_W       (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .count_in (count_in),
        .dir_up   (dir_up),
        .clr      (clr),
        .digit_val(digit_val),
        .valid    (valid),
        .seg      (seg),
        .ovf_pulse(ovf_pulse),
        .unf_pulse(unf_pulse),
        .wrap_cnt (wrap_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] val;
        logic       ovf;
        logic       unf;
        int         wrap;
        int         at_edge;
    } exp_t;

    exp_t       q[$];
    int         edge_cnt = 0;
    int         n_cmp = 0;
    int         n_err = 0;
    logic [6:0] seg_tab[16];

    initial begin
        seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    end

    always @(posedge clk) edge_cnt++;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // Called at a negedge; the following posedge is edge 1 of the latency count.
    task automatic apply(input logic [3:0] v, input logic d, input int hold, input bit acc,
                         input bit ovf, input bit unf, input int wrap, input bit do_clr);
        exp_t e;
        count_in = v;
        dir_up   = d;
        if (acc) begin
            e.val     = v;
            e.ovf     = ovf;
            e.unf     = unf;
            e.wrap    = wrap;
            e.at_edge = edge_cnt + STABLE + 3;
            q.push_back(e);
        end
        if (do_clr) begin
            repeat (STABLE + 2) @(negedge clk);
            clr = 1'b1;
            @(negedge clk);
            clr = 1'b0;
            repeat (hold - STABLE - 3) @(negedge clk);
        end else begin
            repeat (hold) @(negedge clk);
        end
    endtask

    // Monitor: any change of digit_val/valid or any pulse is an output event.
    initial begin
        logic [3:0] prev_d;
        logic       prev_v;
        logic [6:0] exp_seg, pend_seg;
        bit         pend;
        exp_t       e;
        prev_d  = 4'd0;
        prev_v  = 1'b0;
        exp_seg = 7'h40;
        pend_seg = 7'h40;
        pend    = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                exp_seg = 7'h40;
                pend    = 1'b0;
                prev_d  = digit_val;
                prev_v  = valid;
            end else begin
                if (pend) begin
                    exp_seg = pend_seg;
                    pend    = 1'b0;
                end
                check("seg", int'(seg), int'(exp_seg));
                if (digit_val != prev_d || valid != prev_v || ovf_pulse || unf_pulse) begin
                    if (q.size() == 0) begin
                        check("unexpected_event", 1, 0);
                    end else begin
                        e = q.pop_front();
                        check("event_edge", edge_cnt, e.at_edge);
                        check("digit_val", int'(digit_val), int'(e.val));
                        check("valid", int'(valid), 1);
                        check("ovf_pulse", int'(ovf_pulse), int'(e.ovf));
                        check("unf_pulse", int'(unf_pulse), int'(e.unf));
                        check("wrap_cnt", int'(wrap_cnt), e.wrap);
                        pend_seg = seg_tab[e.val];
                        pend     = 1'b1;
                    end
                end
                prev_d = digit_val;
                prev_v = valid;
            end
        end
    end

    initial begin
        #1 rst_n = 1'b0;
        count_in = 4'd5;
        dir_up   = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // First acceptance after reset: no pulse.
        apply(4'd5, 1'b1, 10, 1, 0, 0, 0, 0);
        // Up count through the top: overflow on 15->0.
        apply(4'd13, 1'b1, 10, 1, 0, 0, 0, 0);
        apply(4'd14, 1'b1, 10, 1, 0, 0, 0, 0);
        apply(4'd15, 1'b1, 10, 1, 0, 0, 0, 0);
        apply(4'd0,  1'b1, 10, 1, 1, 0, 1, 0);
        // Down count: underflow, then a saturated underflow.
        apply(4'd1,  1'b0, 10, 1, 0, 0, 1, 0);
        apply(4'd0,  1'b0, 10, 1, 0, 0, 1, 0);
        apply(4'd15, 1'b0, 10, 1, 0, 1, 0, 0);
        apply(4'd0,  1'b0, 10, 1, 0, 0, 0, 0);  // 15->0 counting down: not a wrap
        apply(4'd15, 1'b0, 10, 1, 0, 1, 0, 0);
        // Glitch rejection around the hold-time boundary.
        apply(4'd7,  1'b1, 10, 1, 0, 0, 0, 0);
        apply(4'd3,  1'b1, 2,  0, 0, 0, 0, 0);
        apply(4'd7,  1'b1, 10, 0, 0, 0, 0, 0);
        apply(4'd3,  1'b1, STABLE, 0, 0, 0, 0, 0);
        apply(4'd7,  1'b1, 10, 0, 0, 0, 0, 0);
        apply(4'd3,  1'b1, STABLE + 1, 1, 0, 0, 0, 0);
        apply(4'd7,  1'b1, 10, 1, 0, 0, 0, 0);
        // Climb the tally to all-ones, then overflow once more.
        for (int i = 1; i <= 255; i++) begin
            apply(4'd15, 1'b1, 8, 1, 0, 0, i - 1, 0);
            apply(4'd0,  1'b1, 8, 1, 1, 0, i, 0);
        end
        apply(4'd15, 1'b1, 8, 1, 0, 0, 255, 0);
        apply(4'd0,  1'b1, 8, 1, 1, 0, 255, 0);
        // clr coincident with a qualifying accept.
        apply(4'd15, 1'b1, 8, 1, 0, 0, 255, 0);
        apply(4'd0,  1'b1, 10, 1, 0, 0, 0, 1);
        apply(4'd15, 1'b1, 8, 1, 0, 0, 0, 0);
        apply(4'd0,  1'b1, 8, 1, 1, 0, 1, 0);

        // Reset with a candidate two clocks into its stability count.
        count_in = 4'd9;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_digit_val", int'(digit_val), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_seg", int'(seg), 'h40);
        check("rst_ovf", int'(ovf_pulse), 0);
        check("rst_unf", int'(unf_pulse), 0);
        check("rst_wrap_cnt", int'(wrap_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        apply(4'd9, 1'b1, 12, 1, 0, 0, 0, 0);

        check("pending_events", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
